bus_sram_slave: RTL and testbench

BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

---
 rtl/bus_sram_slave.sv | 121 ++++++++++++
 tb/tb_bus_sram_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_slave.sv
// Bus-attached single-port SRAM slave with programmable wait states.
// Out-of-window accesses complete normally but write nothing, read zero and are counted.
module bus_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic [7:0]  oor_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] req_addr_q, req_wdata_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_strb;
    logic [31:0] byte_off, word_off;
    logic [AW-1:0] idx;
    logic        in_range, enter_resp, mem_we, mem_re;
    logic [31:0] rd_q;
    logic        rd_sel_q;
    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (valid) begin
                if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (!valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, before
    // the request registers have captured anything, so use the live bus there.
    always_comb begin
        acc_addr  = req_addr_q;
        acc_wdata = req_wdata_q;
        acc_strb  = req_wstrb_q;
        if (state_q == IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_strb  = wstrb;
        end
    end

    // Base is window-aligned, so the full-width offset shifted down equals the
    // 30-bit word difference and the low address bits drop out naturally.
    assign byte_off   = acc_addr - BASE_ADDR;
    assign word_off   = byte_off >> 2;
    assign in_range   = word_off < 32'(DEPTH_WORDS);
    assign idx        = word_off[AW-1:0];
    assign enter_resp = (state_d == RESP) && !rst;
    assign mem_we     = enter_resp && in_range && (|acc_strb);
    assign mem_re     = enter_resp && in_range && !(|acc_strb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rd_sel_q  <= 1'b0;
            oor_count <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= mem_re;
            if (enter_resp && !in_range && oor_count != 8'hFF)
                oor_count <= oor_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && valid) begin
            req_addr_q  <= addr;
            req_wdata_q <= wdata;
            req_wstrb_q <= wstrb;
        end
    end

    // Unreset storage: single-port RAM with byte enables and registered read.
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (acc_strb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        if (mem_re) rd_q <= mem[idx];
    end

    assign ready = (state_q == RESP);
    assign rdata = (ready && rd_sel_q) ? rd_q : 32'h0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Three slave instances with different window/wait settings, driven by directed
// and random transactions and compared against a byte-level memory model.
module tb_bus_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd [3];
    logic [7:0]  oc [3];

    int checks   = 0;
    int failures = 0;

    int unsigned WC [3] = '{1, 0, 3};
    logic [31:0] BA [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    int unsigned DW [3] = '{1024, 16, 64};

    logic [31:0] mdat [int];
    logic [3:0]  mkn  [int];
    int          exp_oc [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    bus_sram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .valid(vld[0]), .ready(rdy[0]), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rd[0]), .oor_count(oc[0]));
    bus_sram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .valid(vld[1]), .ready(rdy[1]), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rd[1]), .oor_count(oc[1]));
    bus_sram_slave #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .valid(vld[2]), .ready(rdy[2]), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rd[2]), .oor_count(oc[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance k; model decides expected rdata,
    // latency and out-of-range count from the address window arithmetic.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] obs);
        int lat;
        longint off;
        bit inr;
        int key;
        logic [31:0] e, m, w;
        off = longint'(a) - longint'(BA[k]);
        inr = (off >= 0) && (off < longint'(DW[k]) * 4);
        key = inr ? (k * 65536 + int'(off >>> 2)) : -1;
        e = 32'h0;
        m = 32'hFFFF_FFFF;
        if (inr && s == 4'h0) begin
            m = 32'h0;
            if (mkn.exists(key))
                for (int i = 0; i < 4; i++)
                    if (mkn[key][i]) begin
                        m[8*i +: 8] = 8'hFF;
                        w = mdat[key];
                        e[8*i +: 8] = w[8*i +: 8];
                    end
        end
        if (inr && s != 4'h0) begin
            if (!mkn.exists(key)) begin mkn[key] = 4'h0; mdat[key] = 32'h0; end
            w = mdat[key];
            for (int i = 0; i < 4; i++)
                if (s[i]) begin
                    w[8*i +: 8] = d[8*i +: 8];
                    mkn[key][i] = 1'b1;
                end
            mdat[key] = w;
        end
        if (!inr && exp_oc[k] < 255) exp_oc[k]++;

        @(negedge clk);
        addr = a; wdata = d; wstrb = s; vld[k] = 1'b1;
        @(posedge clk);
        #1 addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy[k] && lat < 40);
        vld[k] = 1'b0;
        obs = rd[k];
        chk($sformatf("latency[u%0d]", k), 32'(lat), 32'(WC[k] + 1));
        chk($sformatf("rdata[u%0d a=%h s=%h]", k, a, s), rd[k] & m, e & m);
        chk($sformatf("oor[u%0d]", k), 32'(oc[k]), 32'(exp_oc[k]));
        @(negedge clk);
        chk($sformatf("ready_drop[u%0d]", k), 32'(rdy[k]), 32'd0);
        chk($sformatf("rdata_idle[u%0d]", k), rd[k], 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] o;
        bit seen;
        rst = 1'b1; vld = 3'b000; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready[u%0d]", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst_rdata[u%0d]", k), rd[k], 32'h0);
            chk($sformatf("rst_oor[u%0d]", k), 32'(oc[k]), 32'd0);
        end
        rst = 1'b0;

        // full-word write, read back, then byte-strobed merge
        txn(0, 32'h10, 32'h1122_3344, 4'hF, o);
        txn(0, 32'h10, 32'h0, 4'h0, o);
        chk("wr_rd_0x10", o, 32'h1122_3344);
        txn(0, 32'h12, 32'hAABB_CCDD, 4'b0101, o);
        txn(0, 32'h11, 32'h0, 4'h0, o);
        chk("strobe_merge", o, 32'h11BB_33DD);

        // zero-wait instance: held valid gives a ready pulse every other cycle
        txn(1, 32'h1004, 32'hCAFE_F00D, 4'hF, o);
        @(negedge clk);
        addr = 32'h1004; wstrb = 4'h0; vld[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready[%0d]", i), 32'(rdy[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_rdata[%0d]", i), rd[1], (i % 2 == 0) ? 32'hCAFE_F00D : 32'h0);
        end
        vld[1] = 1'b0;
        @(negedge clk);

        // abort in WAIT leaves memory and counter untouched
        txn(2, 32'h20, 32'h5A5A_0001, 4'hF, o);
        @(negedge clk);
        addr = 32'h20; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; vld[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[2] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= rdy[2];
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_oor", 32'(oc[2]), 32'd0);
        txn(2, 32'h20, 32'h0, 4'h0, o);
        chk("abort_prior", o, 32'h5A5A_0001);

        // out-of-range reads and counter saturation
        txn(1, 32'h2000, 32'h0, 4'h0, o);
        chk("oor_rdata", o, 32'h0);
        chk("oor_first", 32'(oc[1]), 32'd1);
        repeat (299) txn(1, 32'h2000, 32'h0, 4'h0, o);
        chk("oor_saturate", 32'(oc[1]), 32'hFF);

        // randomized mix over all instances
        for (int n = 0; n < 150; n++) begin
            int k;
            logic [31:0] a, d;
            logic [3:0] s;
            k = $urandom_range(0, 2);
            d = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) != 0)
                a = BA[k] + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            else
                a = BA[k] + 32'(DW[k] * 4) + 32'($urandom_range(0, 4095));
            txn(k, a, d, s, o);
        end

        // reset during WAIT of a write discards it; memory survives reset
        txn(2, 32'h30, 32'h0BAD_C0DE, 4'hF, o);
        @(negedge clk);
        addr = 32'h30; wdata = 32'h1234_5678; wstrb = 4'hF; vld[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; vld[2] = 1'b0;
        for (int k = 0; k < 3; k++) exp_oc[k] = 0;
        chk("rstwait_ready", 32'(rdy[2]), 32'd0);
        chk("rstwait_oor2", 32'(oc[2]), 32'd0);
        chk("rstwait_oor1", 32'(oc[1]), 32'd0);
        txn(2, 32'h30, 32'h0, 4'h0, o);
        chk("rstwait_mem", o, 32'h0BAD_C0DE);
        txn(0, 32'h10, 32'h0, 4'h0, o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
